// File: rtl/multicycle_controller.sv
// Sequencing FSM for a multicycle RV32I core: steps each instruction through
// fetch/decode/execute/memory/writeback and drives the shared datapath controls.
module multicycle_controller #(
    parameter bit WAIT_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       RegWrite,
    output logic       Illegal,
    output logic [3:0] State
);

    localparam int unsigned STATE_W = 4;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_RTYP = 7'b0110011;
    localparam logic [6:0] OP_ITYP = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_HALT     = 4'd11
    } state_t;

    typedef enum logic [1:0] {
        OPSEL_ADD   = 2'd0,
        OPSEL_SUB   = 2'd1,
        OPSEL_FUNCT = 2'd2
    } alu_op_t;

    state_t     state_q;
    state_t     state_d;
    alu_op_t    alu_op;
    logic       ready;
    logic       pc_write_c;
    logic       mem_write_c;
    logic       ir_write_c;
    logic       reg_write_c;
    logic       illegal_c;

    assign ready = WAIT_EN ? MemReady : 1'b1;

    // State register: the only storage in the controller.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-state datapath controls.
    always_comb begin
        state_d     = S_FETCH;
        alu_op      = OPSEL_ADD;
        pc_write_c  = 1'b0;
        mem_write_c = 1'b0;
        ir_write_c  = 1'b0;
        reg_write_c = 1'b0;
        illegal_c   = 1'b0;
        AdrSrc      = 1'b0;
        ResultSrc   = 2'b00;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        case (state_q)
            S_FETCH: begin
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
                ir_write_c = ready;
                pc_write_c = ready;
                state_d    = ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYP:      state_d = S_EXECUTER;
                    OP_ITYP:      state_d = S_EXECUTEI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_HALT;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc  = 1'b1;
                state_d = ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                ResultSrc   = 2'b01;
                reg_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc      = 1'b1;
                mem_write_c = 1'b1;
                state_d     = ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECUTER: begin
                ALUSrcA = 2'b10;
                alu_op  = OPSEL_FUNCT;
                state_d = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_op  = OPSEL_FUNCT;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            S_BEQ: begin
                ALUSrcA    = 2'b10;
                alu_op     = OPSEL_SUB;
                pc_write_c = Zero;
                state_d    = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                pc_write_c = 1'b1;
                state_d    = S_ALUWB;
            end
            S_HALT: begin
                illegal_c = 1'b1;
                state_d   = S_HALT;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // ALU operation; sub only for R-type (op[5]) so addi ignores Instr[30].
    always_comb begin
        ALUControl = ALU_ADD;
        case (alu_op)
            OPSEL_SUB: ALUControl = ALU_SUB;
            OPSEL_FUNCT: begin
                case (funct3)
                    3'b000:  ALUControl = (op[5] & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  ALUControl = ALU_SLT;
                    3'b110:  ALUControl = ALU_OR;
                    3'b111:  ALUControl = ALU_AND;
                    default: ALUControl = ALU_ADD;
                endcase
            end
            default: ALUControl = ALU_ADD;
        endcase
    end

    // Immediate format follows the opcode in every state.
    always_comb begin
        ImmSrc = 2'b00;
        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    // Strobes and the halt flag drop with reset, without waiting for a clock.
    assign PCWrite  = pc_write_c  & reset;
    assign MemWrite = mem_write_c & reset;
    assign IRWrite  = ir_write_c  & reset;
    assign RegWrite = reg_write_c & reset;
    assign Illegal  = illegal_c   & reset;
    assign State    = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class
// through its state sequence and checks controls against hand-derived values.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       MemReady;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] State;

    int n_cmp = 0;
    int n_err = 0;

    multicycle_controller dut (
        .clk       (clk),
        .reset     (reset),
        .op        (op),
        .funct3    (funct3),
        .funct7b5  (funct7b5),
        .Zero      (Zero),
        .MemReady  (MemReady),
        .PCWrite   (PCWrite),
        .AdrSrc    (AdrSrc),
        .MemWrite  (MemWrite),
        .IRWrite   (IRWrite),
        .ResultSrc (ResultSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ImmSrc    (ImmSrc),
        .ALUControl(ALUControl),
        .RegWrite  (RegWrite),
        .Illegal   (Illegal),
        .State     (State)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // {PCWrite, IRWrite, MemWrite, RegWrite}
    function automatic logic [7:0] strobes();
        return {4'b0, PCWrite, IRWrite, MemWrite, RegWrite};
    endfunction

    initial begin
        reset = 1'b0; op = 7'b0000011; funct3 = 3'b000; funct7b5 = 1'b0;
        Zero = 1'b0; MemReady = 1'b1;
        #3;
        chk("rst_state", 8'(State), 8'd0);
        chk("rst_strobes", strobes(), 8'h0);
        chk("rst_illegal", 8'(Illegal), 8'd0);
        #9 reset = 1'b1;
        #1;

        // lw: 0,1,2,3,4,0
        chk("lw_c1_state", 8'(State), 8'd0);
        chk("lw_c1_strobes", strobes(), 8'b1100);
        chk("lw_c1_alusrcb", 8'(ALUSrcB), 8'd2);
        chk("lw_c1_result", 8'(ResultSrc), 8'd2);
        tick();
        chk("lw_c2_state", 8'(State), 8'd1);
        chk("lw_c2_strobes", strobes(), 8'h0);
        chk("lw_c2_srca", 8'(ALUSrcA), 8'd1);
        tick();
        chk("lw_c3_state", 8'(State), 8'd2);
        chk("lw_c3_srca", 8'(ALUSrcA), 8'd2);
        chk("lw_c3_srcb", 8'(ALUSrcB), 8'd1);
        tick();
        chk("lw_c4_state", 8'(State), 8'd3);
        chk("lw_c4_adrsrc", 8'(AdrSrc), 8'd1);
        chk("lw_c4_strobes", strobes(), 8'h0);
        tick();
        chk("lw_c5_state", 8'(State), 8'd4);
        chk("lw_c5_strobes", strobes(), 8'b0001);
        chk("lw_c5_result", 8'(ResultSrc), 8'd1);
        tick();
        chk("lw_done_state", 8'(State), 8'd0);

        // sw with three wait cycles in MEMWRITE
        op = 7'b0100011;
        #1;
        chk("sw_fetch_imm", 8'(ImmSrc), 8'd1);
        tick();
        chk("sw_decode_state", 8'(State), 8'd1);
        tick();
        chk("sw_memadr_state", 8'(State), 8'd2);
        MemReady = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) MemReady = 1'b1;
            #1;
            chk("sw_mw_state", 8'(State), 8'd5);
            chk("sw_mw_memwrite", 8'(MemWrite), 8'd1);
            chk("sw_mw_adrsrc", 8'(AdrSrc), 8'd1);
            chk("sw_mw_imm", 8'(ImmSrc), 8'd1);
            tick();
        end
        chk("sw_done_state", 8'(State), 8'd0);
        chk("sw_done_memwrite", 8'(MemWrite), 8'd0);

        // FETCH wait then R-type sub / slt
        op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1; MemReady = 1'b0;
        #1;
        chk("fetch_wait_strobes", strobes(), 8'h0);
        tick();
        chk("fetch_wait_state", 8'(State), 8'd0);
        MemReady = 1'b1;
        #1;
        chk("fetch_rdy_strobes", strobes(), 8'b1100);
        tick();
        tick();
        chk("r_exec_state", 8'(State), 8'd6);
        chk("r_sub_aluctl", 8'(ALUControl), 8'b001);
        chk("r_exec_srcb", 8'(ALUSrcB), 8'd0);
        funct3 = 3'b010;
        #1;
        chk("r_slt_aluctl", 8'(ALUControl), 8'b101);
        tick();
        chk("r_aluwb_state", 8'(State), 8'd8);
        chk("r_aluwb_strobes", strobes(), 8'b0001);
        chk("r_aluwb_result", 8'(ResultSrc), 8'd0);
        tick();
        chk("r_done_state", 8'(State), 8'd0);

        // I-type: addi with Instr[30]=1 stays add; and/or decode
        op = 7'b0010011; funct3 = 3'b000; funct7b5 = 1'b1;
        tick();
        tick();
        chk("i_exec_state", 8'(State), 8'd7);
        chk("i_addi_aluctl", 8'(ALUControl), 8'b000);
        chk("i_exec_srcb", 8'(ALUSrcB), 8'd1);
        funct3 = 3'b111;
        #1;
        chk("i_and_aluctl", 8'(ALUControl), 8'b010);
        funct3 = 3'b110;
        #1;
        chk("i_or_aluctl", 8'(ALUControl), 8'b011);
        tick();
        chk("i_aluwb_state", 8'(State), 8'd8);
        tick();
        chk("i_done_state", 8'(State), 8'd0);

        // beq taken and not taken
        op = 7'b1100011; funct3 = 3'b000; Zero = 1'b1;
        tick();
        tick();
        chk("beq_t_state", 8'(State), 8'd9);
        chk("beq_t_pcwrite", 8'(PCWrite), 8'd1);
        chk("beq_t_aluctl", 8'(ALUControl), 8'b001);
        chk("beq_t_imm", 8'(ImmSrc), 8'd2);
        tick();
        chk("beq_t_done", 8'(State), 8'd0);
        Zero = 1'b0;
        tick();
        tick();
        chk("beq_n_state", 8'(State), 8'd9);
        chk("beq_n_pcwrite", 8'(PCWrite), 8'd0);
        tick();
        chk("beq_n_done", 8'(State), 8'd0);

        // jal: 0,1,10,8,0
        op = 7'b1101111;
        tick();
        tick();
        chk("jal_state", 8'(State), 8'd10);
        chk("jal_strobes", strobes(), 8'b1000);
        chk("jal_imm", 8'(ImmSrc), 8'd3);
        chk("jal_srca", 8'(ALUSrcA), 8'd1);
        chk("jal_srcb", 8'(ALUSrcB), 8'd2);
        tick();
        chk("jal_aluwb_state", 8'(State), 8'd8);
        chk("jal_aluwb_strobes", strobes(), 8'b0001);
        tick();
        chk("jal_done_state", 8'(State), 8'd0);

        // illegal opcode halts until reset
        op = 7'b0000000;
        tick();
        tick();
        for (int i = 0; i < 12; i++) begin
            chk("halt_state", 8'(State), 8'd11);
            chk("halt_illegal", 8'(Illegal), 8'd1);
            chk("halt_strobes", strobes(), 8'h0);
            tick();
        end
        #2 reset = 1'b0;
        #1;
        chk("async_rst_state", 8'(State), 8'd0);
        chk("async_rst_illegal", 8'(Illegal), 8'd0);
        chk("async_rst_strobes", strobes(), 8'h0);
        tick();
        chk("held_rst_state", 8'(State), 8'd0);
        op = 7'b0000011;
        reset = 1'b1;
        #1;
        chk("post_rst_strobes", strobes(), 8'b1100);
        tick();
        chk("post_rst_decode", 8'(State), 8'd1);
        tick();
        chk("post_rst_memadr", 8'(State), 8'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Sequencing controller for the multicycle RV32I core, which shares one ALU and one unified instruction/data memory across several cycles per instruction.
- A state machine steps each instruction through fetch, decode, address/execute, memory and writeback, and drives the datapath mux selects, write strobes and ALU operation.
- Supports lw, sw, R-type ALU, I-type ALU, beq and jal.
- Adds a memory-ready wait handshake and a sticky illegal-instruction halt.

Parameters:
- WAIT_EN, 1: when 1, memory states honour MemReady; when 0, MemReady is ignored and treated as 1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- op  input  7  instruction opcode, Instr[6:0] from the instruction register.
- funct3  input  3  Instr[14:12].
- funct7b5  input  1  Instr[30].
- Zero  input  1  ALU zero flag.
- MemReady  input  1  memory completes the current access this cycle.
- PCWrite  output  1  PC register enable.
- AdrSrc  output  1  memory address select: 0 = PC, 1 = ALUOut.
- MemWrite  output  1  memory write strobe.
- IRWrite  output  1  instruction register and OldPC enable.
- ResultSrc  output  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  output  2  ALU A select: 00 = PC, 01 = OldPC, 10 = register A.
- ALUSrcB  output  2  ALU B select: 00 = register WriteData, 01 = ImmExt, 10 = constant 4.
- ImmSrc  output  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- ALUControl  output  3  ALU op: 000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt.
- RegWrite  output  1  register file write enable.
- Illegal  output  1  sticky flag: undecodable opcode seen.
- State  output  4  current state encoding, for debug.

Behaviour:
- State register is the only storage.
  - Asynchronous clear to FETCH (0) while reset = 0.
  - All other outputs are combinational from State, op, funct3, funct7b5, Zero and MemReady.
- While reset = 0, PCWrite, IRWrite, MemWrite and RegWrite are forced to 0 and Illegal = 0.
- Any output not listed for a state is 0.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BEQ 9, JAL 10, HALT 11. Codes 12–15 go to FETCH on the next edge.
- FETCH:
  - Drives AdrSrc = 0, ALUSrcA = 00, ALUSrcB = 10, ALUOp = add, ResultSrc = 10.
  - IRWrite = PCWrite = MemReady.
  - Stays in FETCH while MemReady = 0; goes to DECODE when MemReady = 1.
- DECODE:
  - Drives ALUSrcA = 01, ALUSrcB = 01, ALUOp = add (precomputes branch target).
  - Next state by op: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECUTER; 0010011 -> EXECUTEI; 1100011 -> BEQ; 1101111 -> JAL; any other opcode -> HALT.
- MEMADR:
  - Drives ALUSrcA = 10, ALUSrcB = 01, ALUOp = add.
  - Next state: lw -> MEMREAD; sw -> MEMWRITE.
- MEMREAD:
  - Drives ResultSrc = 00, AdrSrc = 1.
  - Stays while MemReady = 0; goes to MEMWB when MemReady = 1.
- MEMWB: drives ResultSrc = 01, RegWrite = 1; next state FETCH.
- MEMWRITE:
  - Drives ResultSrc = 00, AdrSrc = 1, MemWrite = 1, held through wait cycles.
  - Goes to FETCH when MemReady = 1.
- EXECUTER: drives ALUSrcA = 10, ALUSrcB = 00, ALUOp = funct; next state ALUWB.
- EXECUTEI: drives ALUSrcA = 10, ALUSrcB = 01, ALUOp = funct; next state ALUWB.
- ALUWB: drives ResultSrc = 00, RegWrite = 1; next state FETCH.
- BEQ:
  - Drives ALUSrcA = 10, ALUSrcB = 00, ALUOp = sub, ResultSrc = 00.
  - PCWrite = Zero; next state FETCH.
- JAL:
  - Drives ALUSrcA = 01, ALUSrcB = 10, ALUOp = add, ResultSrc = 00, PCWrite = 1.
  - Next state ALUWB (rd = PC + 4).
- HALT: Illegal = 1, all strobes 0; state is held until reset.
- ImmSrc is decoded from op in every state: lw/I-type 00, sw 01, beq 10, jal 11, otherwise 00.
- ALUControl for ALUOp = funct, by funct3:
  - 000: sub if op[5] & funct7b5, else add.
  - 010: slt.
  - 110: or.
  - 111: and.
  - Any other funct3: add.
  - Consequence: addi with Instr[30] = 1 stays add.
- Latency with MemReady tied 1: lw 5 cycles; sw, R-type, I-type and jal 4 cycles; beq 3 cycles.
- Each wait cycle (MemReady = 0 in FETCH, MEMREAD or MEMWRITE) adds one cycle.
- Asserting reset mid-instruction aborts immediately: State = FETCH, strobes drop to 0 in the same cycle without waiting for a clock edge.

Test Plan:
- Reset, MemReady = 1, then op = 0000011 (lw) -> State sequence 0,1,2,3,4,0. IRWrite = PCWrite = 1 only in cycle 1; RegWrite = 1 with ResultSrc = 01 only in cycle 5.
- sw (0100011) with MemReady low for 3 cycles in MEMWRITE -> MemWrite = 1 and AdrSrc = 1 for 4 consecutive cycles, then State = 0. ImmSrc = 01 throughout.
- R-type, funct3 = 000, funct7b5 = 1 -> ALUControl = 001 in EXECUTER. With funct3 = 010 -> 101. I-type (0010011), funct3 = 000, funct7b5 = 1 -> ALUControl = 000.
- beq with Zero = 1 -> PCWrite = 1 in BEQ. With Zero = 0 -> PCWrite = 0. Both return to FETCH after 3 cycles.
- jal (1101111) -> State 0,1,10,8,0: PCWrite = 1 in JAL, RegWrite = 1 in ALUWB, ImmSrc = 11.
- Illegal opcode 0000000 -> State = 11, Illegal = 1, held for 10+ cycles. Assert reset (0) mid-cycle -> State = 0 and all strobes 0 asynchronously. On release, the next fetch proceeds normally.
